// File: rtl/tppe_job_scheduler.sv
// Batch sequencer for one TPPE: per neuron it clears the TPPE, fetches the fibre,
// issues it, waits for LIF completion and hands the spike vector downstream.
module tppe_job_scheduler #(
    parameter int TIMESTEPS  = 8,
    parameter int NEURON_W   = 8,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NEURON_W-1:0]  num_neurons,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 fibre_rd_en,
    output logic [NEURON_W-1:0]  fibre_rd_addr,
    input  logic                 fibre_rd_valid,
    output logic                 tppe_rst_n,
    output logic                 tppe_valid_input,
    input  logic                 tppe_ready,
    input  logic                 tppe_done,
    input  logic [TIMESTEPS-1:0] tppe_spikes,
    output logic [TIMESTEPS-1:0] spike_out,
    output logic [NEURON_W-1:0]  spike_addr,
    output logic                 spike_valid,
    input  logic                 spike_ready,
    output logic [2:0]           dbg_state
);
    // Handshakes: a beat transfers on a cycle where valid and ready are both high;
    // valid, once raised, and its payload hold steady until that cycle.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_WAIT_F = 3'd3,
        S_ISSUE  = 3'd4,
        S_DRAIN  = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    localparam int CLR_W = (CLR_CYCLES < 2) ? 1 : $clog2(CLR_CYCLES);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [NEURON_W-1:0] count, idx;
    logic [CLR_W-1:0]    clr_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                accept_start, write_hs, last_neuron, drain_done, drain_to;
    logic                busy_d, done_d, fibre_rd_en_d, tppe_rst_n_d, tppe_valid_d, spike_valid_d;

    assign accept_start = (state == S_IDLE) && start;
    assign write_hs     = (state == S_WRITE) && spike_ready;
    assign last_neuron  = (idx == count - 1'b1);
    assign drain_done   = (state == S_DRAIN) && tppe_done;
    assign drain_to     = (state == S_DRAIN) && !tppe_done && (to_cnt == TO_LAST);

    assign fibre_rd_addr = idx;
    assign spike_addr    = idx;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start && num_neurons != '0) state_n = S_CLEAR;
            S_CLEAR:  if (clr_cnt == CLR_LAST) state_n = S_FETCH;
            S_FETCH:  state_n = S_WAIT_F;
            S_WAIT_F: if (fibre_rd_valid) state_n = S_ISSUE;
            S_ISSUE:  if (tppe_ready) state_n = S_DRAIN;
            S_DRAIN:  if (tppe_done || to_cnt == TO_LAST) state_n = S_WRITE;
            S_WRITE:  if (spike_ready) state_n = last_neuron ? S_IDLE : S_CLEAR;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with state.
    always_comb begin
        busy_d        = (state_n != S_IDLE);
        done_d        = (accept_start && num_neurons == '0) || (write_hs && last_neuron);
        fibre_rd_en_d = (state_n == S_FETCH);
        tppe_rst_n_d  = !((state_n == S_IDLE) || (state_n == S_CLEAR));
        tppe_valid_d  = (state_n == S_ISSUE);
        spike_valid_d = (state_n == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            fibre_rd_en      <= 1'b0;
            tppe_rst_n       <= 1'b0;
            tppe_valid_input <= 1'b0;
            spike_valid      <= 1'b0;
        end else begin
            busy             <= busy_d;
            done             <= done_d;
            fibre_rd_en      <= fibre_rd_en_d;
            tppe_rst_n       <= tppe_rst_n_d;
            tppe_valid_input <= tppe_valid_d;
            spike_valid      <= spike_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            idx         <= '0;
            clr_cnt     <= '0;
            to_cnt      <= '0;
            spike_out   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept_start && num_neurons != '0) begin
                count <= num_neurons;
                idx   <= '0;
            end else if (write_hs && !last_neuron) begin
                idx <= idx + 1'b1;
            end
            clr_cnt <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
            to_cnt  <= (state == S_DRAIN) ? to_cnt + 1'b1 : '0;
            // A done landing on the timeout cycle wins over the abort.
            if (drain_done)    spike_out <= tppe_spikes;
            else if (drain_to) spike_out <= '0;
            if (accept_start)  timeout_err <= 1'b0;
            else if (drain_to) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tppe_job_scheduler.sv
// Directed bench for tppe_job_scheduler: batches, stalls, timeout, zero batch
// and mid-batch reset, with hand-computed expectations.
module tb_tppe_job_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] num_neurons;
    logic       busy, done, timeout_err, fibre_rd_en;
    logic [7:0] fibre_rd_addr;
    logic       fibre_rd_valid;
    logic       tppe_rst_n, tppe_valid_input;
    logic       tppe_ready, tppe_done;
    logic [7:0] tppe_spikes, spike_out, spike_addr;
    logic       spike_valid, spike_ready;
    logic [2:0] dbg_state;

    int tests = 0;
    int fails = 0;

    tppe_job_scheduler #(
        .TIMESTEPS(8), .NEURON_W(8), .CLR_CYCLES(2), .TIMEOUT(255), .TO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_neurons(num_neurons),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .fibre_rd_en(fibre_rd_en), .fibre_rd_addr(fibre_rd_addr),
        .fibre_rd_valid(fibre_rd_valid), .tppe_rst_n(tppe_rst_n),
        .tppe_valid_input(tppe_valid_input), .tppe_ready(tppe_ready),
        .tppe_done(tppe_done), .tppe_spikes(tppe_spikes),
        .spike_out(spike_out), .spike_addr(spike_addr),
        .spike_valid(spike_valid), .spike_ready(spike_ready),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_toerr"}, timeout_err, 0);
        chk({tag, "_rd_en"}, fibre_rd_en, 0);
        chk({tag, "_rd_addr"}, fibre_rd_addr, 0);
        chk({tag, "_tppe_rst_n"}, tppe_rst_n, 0);
        chk({tag, "_valid_in"}, tppe_valid_input, 0);
        chk({tag, "_spike_out"}, spike_out, 0);
        chk({tag, "_spike_addr"}, spike_addr, 0);
        chk({tag, "_spike_valid"}, spike_valid, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // Leaves the bench observing the first CLEAR cycle; count is scrambled after capture.
    task automatic start_batch(input logic [7:0] n);
        start = 1'b1;
        num_neurons = n;
        tick();
        start = 1'b0;
        num_neurons = 8'($urandom_range(0, 255));
        chk("start_busy", busy, 1);
        chk("start_state", dbg_state, 1);
    endtask

    // From the first CLEAR cycle to the first DRAIN cycle with instant responses.
    task automatic to_drain(input logic [7:0] ia);
        chk("clr1_rst", tppe_rst_n, 0);
        chk("clr1_rd", fibre_rd_en, 0);
        tick();
        chk("clr2_rst", tppe_rst_n, 0);
        chk("clr2_rd", fibre_rd_en, 0);
        tick();
        chk("fetch_rd", fibre_rd_en, 1);
        chk("fetch_addr", fibre_rd_addr, ia);
        chk("fetch_rst", tppe_rst_n, 1);
        fibre_rd_valid = 1'b1;
        tppe_ready = 1'b1;
        tick();
        chk("waitf_rd", fibre_rd_en, 0);
        chk("waitf_vi", tppe_valid_input, 0);
        tick();
        chk("issue_vi", tppe_valid_input, 1);
        tick();
        fibre_rd_valid = 1'b0;
        tppe_ready = 1'b0;
        chk("drain_vi", tppe_valid_input, 0);
        chk("drain_state", dbg_state, 5);
    endtask

    // One full neuron with tppe_done on the fourth DRAIN cycle.
    task automatic run_neuron(input logic [7:0] ia, input logic [7:0] sp, input bit last);
        to_drain(ia);
        repeat (3) tick();
        chk("drain4_sv", spike_valid, 0);
        tppe_done = 1'b1;
        tppe_spikes = sp;
        tick();
        tppe_done = 1'b0;
        chk("write_sv", spike_valid, 1);
        chk("write_spikes", spike_out, sp);
        chk("write_addr", spike_addr, ia);
        chk("write_done", done, 0);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
        chk("post_write_sv", spike_valid, 0);
        if (last) begin
            chk("batch_done", done, 1);
            chk("batch_busy", busy, 0);
            tick();
            chk("done_once", done, 0);
        end else begin
            chk("next_busy", busy, 1);
            chk("next_clr_rst", tppe_rst_n, 0);
            chk("next_done", done, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_neurons = 8'd0;
        fibre_rd_valid = 1'b0;
        tppe_ready = 1'b0;
        tppe_done = 1'b0;
        tppe_spikes = 8'd0;
        spike_ready = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_state", dbg_state, 0);

        // Batch of 3, instant responses.
        start_batch(8'd3);
        run_neuron(8'd0, 8'hA5, 1'b0);
        run_neuron(8'd1, 8'h3C, 1'b0);
        run_neuron(8'd2, 8'hFF, 1'b1);

        // ISSUE stall of 10 cycles then WRITE stall of 7 cycles.
        start_batch(8'd2);
        tick();
        tick();
        fibre_rd_valid = 1'b1;
        tick();
        tick();
        fibre_rd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_vi", tppe_valid_input, 1);
            chk("stall_state", dbg_state, 4);
            tick();
        end
        chk("stall_vi_last", tppe_valid_input, 1);
        tppe_ready = 1'b1;
        tick();
        tppe_ready = 1'b0;
        chk("stall_drain", dbg_state, 5);
        chk("stall_drain_vi", tppe_valid_input, 0);
        tppe_done = 1'b1;
        tppe_spikes = 8'h5A;
        tick();
        tppe_done = 1'b0;
        tppe_spikes = 8'h00;
        chk("drain_once", dbg_state, 6);
        for (int i = 0; i < 7; i++) begin
            chk("wstall_sv", spike_valid, 1);
            chk("wstall_spikes", spike_out, 8'h5A);
            chk("wstall_addr", spike_addr, 0);
            chk("wstall_rst", tppe_rst_n, 1);
            tick();
        end
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
        chk("wstall_clear", dbg_state, 1);
        run_neuron(8'd1, 8'h77, 1'b1);

        // Timeout on neuron 0; start is ignored while busy.
        start_batch(8'd2);
        to_drain(8'd0);
        start = 1'b1;
        num_neurons = 8'd0;
        repeat (254) tick();
        start = 1'b0;
        chk("to_c255_state", dbg_state, 5);
        chk("to_c255_err", timeout_err, 0);
        chk("to_busy", busy, 1);
        tick();
        chk("to_write", dbg_state, 6);
        chk("to_spikes", spike_out, 0);
        chk("to_err", timeout_err, 1);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
        chk("to_err_clear", timeout_err, 1);
        run_neuron(8'd1, 8'h81, 1'b1);
        chk("to_err_sticky", timeout_err, 1);

        // Zero batch clears timeout_err, pulses done, never fetches.
        start = 1'b1;
        num_neurons = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_rd", fibre_rd_en, 0);
        chk("zero_err", timeout_err, 0);
        tick();
        chk("zero_done_off", done, 0);
        chk("zero_busy2", busy, 0);
        chk("zero_rd2", fibre_rd_en, 0);

        // tppe_done on the 255th DRAIN cycle wins over the timeout.
        start_batch(8'd1);
        to_drain(8'd0);
        repeat (254) tick();
        tppe_done = 1'b1;
        tppe_spikes = 8'hC3;
        tick();
        tppe_done = 1'b0;
        chk("tie_write", dbg_state, 6);
        chk("tie_spikes", spike_out, 8'hC3);
        chk("tie_err", timeout_err, 0);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
        chk("tie_done", done, 1);
        tick();

        // Reset during DRAIN of neuron 1 of 4, then a fresh batch.
        start_batch(8'd4);
        run_neuron(8'd0, 8'h11, 1'b0);
        to_drain(8'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst_nodone", done, 0);
        chk("midrst_idle", dbg_state, 0);
        start_batch(8'd1);
        run_neuron(8'd0, 8'h22, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
